sha256_stream_core: RTL
=======================

Name: sha256_stream_core

Overview:
Parametrised SHA-256 compression engine. It accepts a stream of pre-padded 512-bit message blocks over a valid/ready handshake, chains them, and returns the full 256-bit digest over a second valid/ready handshake. Rounds-per-cycle is selectable, and an optional double-hash mode (SHA-256 of the 256-bit digest, as used by the miner datapath) is available per message. It sits between the message padder/nonce generator and the digest comparator.

Parameters:
RPC, 1, SHA-256 rounds evaluated per clock; legal values 1, 2, 4, 8; any other value is an elaboration error.
DOUBLE_EN, 1, when 0 the double-hash hardware is removed and blk_double is ignored.

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
blk_valid  input  1  blk_data/blk_first/blk_last/blk_double valid
blk_ready  output  1  core can accept a block this cycle
blk_data  input  512  padded block; [511:480]=W0 ... [31:0]=W15
blk_first  input  1  block starts a new message (chain from IV)
blk_last  input  1  block ends the message
blk_double  input  1  apply second SHA-256 pass; sampled with the last block
digest_valid  output  1  digest holds a result
digest_ready  input  1  consumer accepts digest
digest  output  256  [255:224]=H0 ... [31:0]=H7
busy  output  1  high in every state except WAIT

Behaviour:
- Clock and reset: reset reset_n, asynchronous, active-low; clock clk.
- Reset values: state=WAIT, blk_ready=1, digest_valid=0, digest=0, busy=0, H registers=IV.
- Reset asserted mid-operation aborts the block or message immediately; no partial digest is ever presented.
- States and transitions:
  - WAIT: blk_ready=1. On blk_valid&blk_ready:
    - load W[0..15] from blk_data;
    - chain value CV = IV if blk_first, else the H registers;
    - a..h <= CV; H registers <= CV;
    - latch blk_last and (blk_double & DOUBLE_EN); round counter <= 0; go to ROUND.
  - ROUND: each cycle apply RPC consecutive rounds (unrolled) with the sliding 16-word W schedule; counter += RPC. After 64/RPC cycles go to UPDATE.
  - UPDATE (1 cycle): H <= H + {a..h} (each word mod 2^32).
    - Not last: go to WAIT.
    - Last, double latched, and this is the first pass:
      - W <= {H0+a..H7+h, 32'h80000000, six zero words, 32'd256};
      - a..h <= IV; H <= IV; set pass2 flag; go to ROUND.
    - Otherwise: digest <= H + {a..h}; digest_valid <= 1; go to OUT.
  - OUT: digest_valid and digest held stable. On digest_ready go to WAIT and clear digest_valid and pass2. blk_ready=0.
- Latency:
  - Single pass: digest_valid rises 64/RPC+1 cycles after the accepting edge.
  - Double: 2*(64/RPC+1) cycles.
  - Back-to-back throughput: one block per 64/RPC+2 cycles.
- blk_ready is 0 in ROUND, UPDATE and OUT; blk_valid there is ignored and the data is not consumed.
- blk_first is honoured on every block: a first block arriving mid-message restarts from IV.
- blk_last=0 is legal on any block; the digest is produced only on blk_last.
- K[0..63] and the IV come from constants, not ports.
- All arithmetic is 32-bit, wrap-around. Rotations are pure rotations; sigma0/sigma1 use logical shifts as FIPS 180-4.
- digest_ready high outside OUT has no effect.

Decomposition:
- Package sha256_pkg:
  - K[64] constant array and IV[8] constant;
  - state enum (WAIT, ROUND, UPDATE, OUT);
  - functions rotr, big_sigma0/1, small_sigma0/1, ch, maj;
  - word_t typedef.
- Sub-module sha256_round: combinational single round with inputs {a..h}, W, K and output {a..h}. It is instantiated RPC times in a generate chain, together with the RPC-step W-schedule slice.

Test Plan:
- RPC=1, single block "abc" (first=last=1, double=0) -> digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, digest_valid exactly 65 cycles after accept.
- Empty message, RPC=4 -> e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, latency 17.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" with a 5-cycle gap between blocks -> 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1; blk_ready low throughout each block's processing.
- "abc" with blk_double=1, RPC=2 -> 4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358, latency 66.
- digest_ready held low 20 cycles -> digest stable, blk_ready=0; a new blk_valid is ignored and accepted only after the handshake.
- reset_n pulsed mid-ROUND, then "abc" resent -> outputs zero during reset, correct "abc" digest afterward.

Source files
------------

// File: rtl/sha256_pkg.sv
// SHA-256 constants, state encodings and word-level helper functions
// shared by the stream core and its round datapath.
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam logic [1:0] S_WAIT   = 2'd0;
    localparam logic [1:0] S_ROUND  = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;
    localparam logic [1:0] S_OUT    = 2'd3;

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t x, input word_t y,
                                 input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y,
                                  input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: {a..h} in, {a..h} out.
// Working state is packed with a in [255:224] down to h in [31:0].
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] st_i,
    input  word_t        w_i,
    input  word_t        k_i,
    output logic [255:0] st_o
);

    word_t a, b, c, d, e, f, g, h;
    word_t t1, t2;

    assign {a, b, c, d, e, f, g, h} = st_i;
    assign t1 = h + big_sigma1(e) + ch(e, f, g) + k_i + w_i;
    assign t2 = big_sigma0(a) + maj(a, b, c);
    assign st_o = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_stream_core.sv
// Streaming SHA-256 engine: chains padded blocks, RPC rounds per clock,
// optional second pass over the 256-bit digest.
module sha256_stream_core
    import sha256_pkg::*;
#(
    parameter int RPC       = 1,
    parameter bit DOUBLE_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    input  logic         blk_double,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [255:0] digest,
    output logic         busy
);

    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
        $error("sha256_stream_core: RPC must be 1, 2, 4 or 8");
    end

    logic [1:0]   state_q, state_d;
    logic [255:0] st_q, st_d;
    logic [255:0] h_q, h_d;
    logic [255:0] dig_q, dig_d;
    logic [255:0] hsum;
    word_t        w_q [16];
    word_t        w_d [16];
    logic [5:0]   cnt_q, cnt_d;
    logic         last_q, last_d;
    logic         dbl_q, dbl_d;
    logic         pass2_q, pass2_d;
    logic         dv_q, dv_d;

    // Unrolled round chain; each stage also slides the 16-word schedule.
    for (genvar i = 0; i < RPC; i++) begin : g_stage
        logic [255:0] si, so;
        word_t        wi [16];
        word_t        wo [16];
        if (i == 0) begin : g_head
            assign si = st_q;
            assign wi = w_q;
        end else begin : g_link
            assign si = g_stage[i-1].so;
            assign wi = g_stage[i-1].wo;
        end
        sha256_round u_round (
            .st_i (si),
            .w_i  (wi[0]),
            .k_i  (K[cnt_q + 6'(i)]),
            .st_o (so)
        );
        for (genvar j = 0; j < 15; j++) begin : g_shift
            assign wo[j] = wi[j+1];
        end
        assign wo[15] = small_sigma1(wi[14]) + wi[9]
                      + small_sigma0(wi[1]) + wi[0];
    end

    // Per-word sum of the chain value and the working variables.
    always_comb begin
        hsum = '0;
        for (int k = 0; k < 8; k++) begin
            hsum[255-32*k -: 32] = h_q[255-32*k -: 32] + st_q[255-32*k -: 32];
        end
    end

    // Next-state logic for the block/round/update/output sequence.
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        h_d     = h_q;
        dig_d   = dig_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        dbl_d   = dbl_q;
        pass2_d = pass2_q;
        dv_d    = dv_q;
        case (state_q)
            S_WAIT: begin
                if (blk_valid) begin
                    st_d = blk_first ? IV : h_q;
                    h_d  = blk_first ? IV : h_q;
                    for (int k = 0; k < 16; k++) begin
                        w_d[k] = blk_data[511-32*k -: 32];
                    end
                    last_d  = blk_last;
                    dbl_d   = blk_double & DOUBLE_EN;
                    cnt_d   = '0;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                st_d  = g_stage[RPC-1].so;
                w_d   = g_stage[RPC-1].wo;
                cnt_d = cnt_q + 6'(RPC);
                if (cnt_q == 6'(64 - RPC)) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (!last_q) begin
                    h_d     = hsum;
                    state_d = S_WAIT;
                end else if (dbl_q && !pass2_q) begin
                    for (int k = 0; k < 8; k++) begin
                        w_d[k] = hsum[255-32*k -: 32];
                    end
                    w_d[8] = 32'h80000000;
                    for (int k = 9; k < 15; k++) begin
                        w_d[k] = '0;
                    end
                    w_d[15] = 32'd256;
                    st_d    = IV;
                    h_d     = IV;
                    cnt_d   = '0;
                    pass2_d = 1'b1;
                    state_d = S_ROUND;
                end else begin
                    h_d     = hsum;
                    dig_d   = hsum;
                    dv_d    = 1'b1;
                    state_d = S_OUT;
                end
            end
            default: begin
                if (digest_ready) begin
                    dv_d    = 1'b0;
                    pass2_d = 1'b0;
                    state_d = S_WAIT;
                end
            end
        endcase
    end

    // State registers; reset drops any in-flight block or message.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
            st_q    <= '0;
            h_q     <= IV;
            dig_q   <= '0;
            for (int k = 0; k < 16; k++) begin
                w_q[k] <= '0;
            end
            cnt_q   <= '0;
            last_q  <= 1'b0;
            dbl_q   <= 1'b0;
            pass2_q <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            h_q     <= h_d;
            dig_q   <= dig_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            dbl_q   <= dbl_d;
            pass2_q <= pass2_d;
            dv_q    <= dv_d;
        end
    end

    assign blk_ready    = (state_q == S_WAIT);
    assign busy         = (state_q != S_WAIT);
    assign digest_valid = dv_q;
    assign digest       = dig_q;

endmodule
